// File: rtl/motor_drive_ramp.sv
// motor_drive_ramp: multi-channel signed power command -> direction code + PWM.
// Each channel limits its duty slew per PWM period and holds a dead time
// before it reverses direction. All channels share one period counter.
// Optional build macro MOTOR_DRIVE_BRAKE_EN: during dead time a channel drives
// direction 11 (active brake). When the macro is undefined it drives 00.

module motor_drive_ramp_ch #(
    parameter int PWR_W        = 16,
    parameter int DUTY_W       = 10,
    parameter int PERIOD       = 4000,
    parameter int RAMP_STEP    = 8,
    parameter int DEAD_PERIODS = 4,
    parameter int CNT_W        = $clog2(PERIOD)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              run_en,
    input  logic [PWR_W-1:0]  power,
    input  logic [CNT_W-1:0]  count,
    output logic [1:0]        direction,
    output logic              pwm,
    output logic [DUTY_W-1:0] duty
);
    localparam int DMAX_I = (1 << DUTY_W) - 1;
    localparam int STEP_I = (RAMP_STEP > DMAX_I) ? DMAX_I : RAMP_STEP;
    localparam int MW     = ((PWR_W > DUTY_W) ? PWR_W : DUTY_W) + 1;
    localparam int DW     = (DEAD_PERIODS > 0) ? $clog2(DEAD_PERIODS + 1) : 1;
    localparam int PW     = DUTY_W + $clog2(PERIOD + 1);

    localparam logic [DUTY_W-1:0] DMAX      = DMAX_I[DUTY_W-1:0];
    localparam logic [DUTY_W-1:0] STEP      = STEP_I[DUTY_W-1:0];
    localparam logic [MW-1:0]     DMAX_X    = MW'(DMAX_I);
    localparam logic [DW-1:0]     DEAD_INIT = DW'(DEAD_PERIODS);

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_FWD  = 2'b01;
    localparam logic [1:0] DIR_BWD  = 2'b10;
`ifdef MOTOR_DRIVE_BRAKE_EN
    localparam logic [1:0] DIR_DEAD = 2'b11;
`else
    localparam logic [1:0] DIR_DEAD = 2'b00;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    state_t            state_q, state_n;
    logic [DUTY_W-1:0] duty_q, duty_n, tgt, toward_t, toward_0;
    logic [1:0]        dir_q, dir_n;
    logic [DW-1:0]     dead_q, dead_n;
    logic [CNT_W-1:0]  cmp_q;
    logic              sign;
    logic [PWR_W-1:0]  mag;
    logic [MW-1:0]     mag_x;

    // Target magnitude (|power| saturated to DMAX) and one-step ramp candidates
    always_comb begin
        sign  = power[PWR_W-1];
        mag   = sign ? (~power + PWR_W'(1)) : power;
        mag_x = MW'(mag);
        tgt   = (mag_x > DMAX_X) ? DMAX : mag_x[DUTY_W-1:0];
        toward_0 = (duty_q <= STEP) ? '0 : duty_q - STEP;
        if (duty_q < tgt)
            toward_t = (tgt - duty_q <= STEP) ? tgt : duty_q + STEP;
        else
            toward_t = (duty_q - tgt <= STEP) ? tgt : duty_q - STEP;
    end

    // Channel state machine: evaluated only on the period tick
    always_comb begin
        state_n = state_q;
        duty_n  = duty_q;
        dir_n   = dir_q;
        dead_n  = dead_q;
        if (tick) begin
            if (!run_en) begin
                state_n = IDLE;
                duty_n  = '0;
                dir_n   = DIR_STOP;
                dead_n  = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (tgt != '0) begin
                            state_n = RUN;
                            dir_n   = sign ? DIR_BWD : DIR_FWD;
                            duty_n  = (tgt < STEP) ? tgt : STEP;
                        end
                    end
                    RUN: begin
                        if (tgt == '0 || sign == (dir_q == DIR_BWD)) begin
                            duty_n = toward_t;
                            if (toward_t == '0) begin
                                state_n = IDLE;
                                dir_n   = DIR_STOP;
                            end
                        end else begin
                            // reversal: wind down in the old direction first
                            duty_n = toward_0;
                            if (toward_0 == '0) begin
                                if (DEAD_PERIODS == 0) begin
                                    state_n = IDLE;
                                    dir_n   = DIR_STOP;
                                end else begin
                                    state_n = DEAD;
                                    dir_n   = DIR_DEAD;
                                    dead_n  = DEAD_INIT;
                                end
                            end
                        end
                    end
                    DEAD: begin
                        duty_n = '0;
                        if (dead_q <= DW'(1)) begin
                            state_n = IDLE;
                            dir_n   = DIR_STOP;
                            dead_n  = '0;
                        end else begin
                            dead_n = dead_q - DW'(1);
                        end
                    end
                    default: begin
                        state_n = IDLE;
                        duty_n  = '0;
                        dir_n   = DIR_STOP;
                        dead_n  = '0;
                    end
                endcase
            end
        end
    end

    // State, duty, direction and compare value registered together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            duty_q  <= '0;
            dir_q   <= DIR_STOP;
            dead_q  <= '0;
            cmp_q   <= '0;
        end else begin
            state_q <= state_n;
            duty_q  <= duty_n;
            dir_q   <= dir_n;
            dead_q  <= dead_n;
            cmp_q   <= CNT_W'((PW'(duty_n) * PW'(PERIOD)) >> DUTY_W);
        end
    end

    // PWM output: one cycle behind the shared counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pwm <= 1'b0;
        else       pwm <= (count < cmp_q);
    end

    assign direction = dir_q;
    assign duty      = duty_q;
endmodule

module motor_drive_ramp #(
    parameter int CHANNELS     = 2,
    parameter int PWR_W        = 16,
    parameter int DUTY_W       = 10,
    parameter int PERIOD       = 4000,
    parameter int RAMP_STEP    = 8,
    parameter int DEAD_PERIODS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [CHANNELS*PWR_W-1:0]  power,
    output logic [2*CHANNELS-1:0]      direction,
    output logic [CHANNELS-1:0]        pwm,
    output logic [CHANNELS*DUTY_W-1:0] duty_out,
    output logic                       period_start
);
    localparam int CNT_W = $clog2(PERIOD);

    logic [CNT_W-1:0] count;
    logic             tick, dis_pend, run_en;

    assign tick   = (count == CNT_W'(PERIOD - 1));
    assign run_en = enable & ~dis_pend;

    // Shared PWM period counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     count <= '0;
        else if (tick) count <= '0;
        else           count <= count + CNT_W'(1);
    end

    // period_start is high while count==0 (tick delayed one cycle)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) period_start <= 1'b0;
        else       period_start <= tick;
    end

    // Remember any enable drop within the period so the next tick idles
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        dis_pend <= 1'b0;
        else if (tick)    dis_pend <= 1'b0;
        else if (!enable) dis_pend <= 1'b1;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        motor_drive_ramp_ch #(
            .PWR_W       (PWR_W),
            .DUTY_W      (DUTY_W),
            .PERIOD      (PERIOD),
            .RAMP_STEP   (RAMP_STEP),
            .DEAD_PERIODS(DEAD_PERIODS),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .tick     (tick),
            .run_en   (run_en),
            .power    (power[i*PWR_W +: PWR_W]),
            .count    (count),
            .direction(direction[2*i +: 2]),
            .pwm      (pwm[i]),
            .duty     (duty_out[i*DUTY_W +: DUTY_W])
        );
    end
endmodule

// File: tb/tb_motor_drive_ramp.sv
// Randomized bench for motor_drive_ramp with a per-channel behavioural model
// (integer duty / sign / dead-period count) and hand-computed scenario checks.
module tb_motor_drive_ramp;
    localparam int CH = 2, PW = 16, DW = 10, PER = 100, STEP = 256, DEADP = 4;
    localparam int DMAX = 1023;
`ifdef MOTOR_DRIVE_BRAKE_EN
    localparam logic [1:0] DEAD_CODE = 2'b11;
`else
    localparam logic [1:0] DEAD_CODE = 2'b00;
`endif

    logic clk = 1'b0, reset = 1'b1, enable = 1'b0;
    logic [CH*PW-1:0] power = '0;
    logic [2*CH-1:0]  direction;
    logic [CH-1:0]    pwm;
    logic [CH*DW-1:0] duty_out;
    logic             period_start;

    motor_drive_ramp #(
        .CHANNELS(CH), .PWR_W(PW), .DUTY_W(DW), .PERIOD(PER),
        .RAMP_STEP(STEP), .DEAD_PERIODS(DEADP)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .power(power),
        .direction(direction), .pwm(pwm), .duty_out(duty_out),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    bit chk_on = 0;

    // model state: counter position, pending disable, per-channel duty/sign/dead
    int m_cnt = 0;
    bit m_dis = 0;
    int m_duty[CH], m_sgn[CH], m_dead[CH];
    bit e_pwm[CH];
    bit e_ps = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_dir(input int c);
        if (m_dead[c] > 0) return DEAD_CODE;
        if (m_sgn[c] > 0)  return 2'b01;
        if (m_sgn[c] < 0)  return 2'b10;
        return 2'b00;
    endfunction

    function automatic int exp_cmp(input int c);
        return (m_duty[c] * PER) / 1024;
    endfunction

    // one PWM-period update of channel c from the rules
    task automatic model_tick(input int c, input bit ok);
        int p, t, s;
        p = $signed(power[c*PW +: PW]);
        t = (p < 0) ? -p : p;
        if (t > DMAX) t = DMAX;
        s = (p < 0) ? -1 : 1;
        if (!ok) begin
            m_duty[c] = 0; m_sgn[c] = 0; m_dead[c] = 0;
        end else if (m_dead[c] > 0) begin
            m_dead[c]--;
        end else if (m_sgn[c] == 0) begin
            if (t > 0) begin
                m_sgn[c]  = s;
                m_duty[c] = (t < STEP) ? t : STEP;
            end
        end else if (t == 0 || s == m_sgn[c]) begin
            if (m_duty[c] < t) m_duty[c] = (m_duty[c] + STEP > t) ? t : m_duty[c] + STEP;
            else               m_duty[c] = (m_duty[c] - STEP < t) ? t : m_duty[c] - STEP;
            if (m_duty[c] == 0) m_sgn[c] = 0;
        end else begin
            m_duty[c] = (m_duty[c] > STEP) ? m_duty[c] - STEP : 0;
            if (m_duty[c] == 0) begin
                m_sgn[c] = 0; m_dead[c] = DEADP;
            end
        end
    endtask

    // model advance on each clock
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_cnt = 0; m_dis = 0; e_ps = 0;
            for (int c = 0; c < CH; c++) begin
                m_duty[c] = 0; m_sgn[c] = 0; m_dead[c] = 0; e_pwm[c] = 0;
            end
        end else begin
            for (int c = 0; c < CH; c++) e_pwm[c] = (m_cnt < exp_cmp(c));
            e_ps = (m_cnt == PER - 1);
            if (m_cnt == PER - 1) begin
                for (int c = 0; c < CH; c++) model_tick(c, enable && !m_dis);
                m_dis = 0;
                m_cnt = 0;
            end else begin
                if (!enable) m_dis = 1;
                m_cnt++;
            end
        end
    end

    // every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (chk_on && !reset) begin
            for (int c = 0; c < CH; c++) begin
                chk($sformatf("cyc duty ch%0d", c), 32'(duty_out[c*DW +: DW]), 32'(m_duty[c]));
                chk($sformatf("cyc dir ch%0d", c), 32'(direction[2*c +: 2]), 32'(exp_dir(c)));
                chk($sformatf("cyc pwm ch%0d", c), 32'(pwm[c]), 32'(e_pwm[c]));
            end
            chk("cyc period_start", 32'(period_start), 32'(e_ps));
        end
    end

    task automatic setp(input int c, input int v);
        power[c*PW +: PW] = v[PW-1:0];
    endtask

    task automatic periods(input int n);
        repeat (n * PER) @(negedge clk);
    endtask

    task automatic align();
        int b = 0;
        @(negedge clk);
        while (m_cnt != 0 && b < 2 * PER) begin
            @(negedge clk);
            b++;
        end
        chk("align bound", 32'(m_cnt), 32'd0);
    endtask

    // literal expectation checked against both the DUT and the model
    task automatic lit(input string name, input int c, input int d, input logic [1:0] dr);
        chk({name, " duty"}, 32'(duty_out[c*DW +: DW]), 32'(d));
        chk({name, " dir"}, 32'(direction[2*c +: 2]), 32'(dr));
        chk({name, " model duty"}, 32'(m_duty[c]), 32'(d));
        chk({name, " model dir"}, 32'(exp_dir(c)), 32'(dr));
    endtask

    task automatic count_pwm(output int h0, output int h1);
        h0 = 0; h1 = 0;
        repeat (PER) begin
            @(negedge clk);
            h0 += int'(pwm[0]);
            h1 += int'(pwm[1]);
        end
    endtask

    function automatic int pick();
        case ($urandom_range(0, 7))
            0: return 0;
            1: return int'($urandom_range(1, 300));
            2: return -int'($urandom_range(1, 300));
            3: return 600;
            4: return -600;
            5: return 5000;
            6: return -32768;
            default: return int'($urandom());
        endcase
    endfunction

    initial begin
        int h0, h1;
        repeat (3) @(negedge clk);
        chk("reset duty_out", 32'(duty_out), 32'd0);
        chk("reset direction", 32'(direction), 32'd0);
        chk("reset pwm", 32'(pwm), 32'd0);
        chk("reset period_start", 32'(period_start), 32'd0);
        reset = 1'b0;
        chk_on = 1;

        // 1: ramp ch0 to +600, ch1 stays idle
        enable = 1'b1; setp(0, 600); setp(1, 0);
        periods(1); lit("t1 p1", 0, 256, 2'b01); lit("t1 ch1", 1, 0, 2'b00);
        periods(1); lit("t1 p2", 0, 512, 2'b01);
        periods(1); lit("t1 p3", 0, 600, 2'b01);
        count_pwm(h0, h1);
        chk("t1 pwm high cycles", 32'(h0), 32'd58);
        chk("t1 ch1 pwm high cycles", 32'(h1), 32'd0);
        lit("t1 hold", 0, 600, 2'b01);

        // 2: reversal to -300 with dead time
        setp(0, -300);
        periods(1); lit("t2 p1", 0, 344, 2'b01);
        periods(1); lit("t2 p2", 0, 88, 2'b01);
        periods(1); lit("t2 dead start", 0, 0, DEAD_CODE);
        periods(3); lit("t2 dead end", 0, 0, DEAD_CODE);
        periods(1); lit("t2 idle", 0, 0, 2'b00);
        periods(1); lit("t2 rev1", 0, 256, 2'b10);
        periods(1); lit("t2 rev2", 0, 300, 2'b10);

        // 3: saturation of both extremes
        setp(0, -32768); setp(1, 5000);
        periods(4);
        lit("t3 ch0", 0, 1023, 2'b10);
        lit("t3 ch1", 1, 1023, 2'b01);
        count_pwm(h0, h1);
        chk("t3 ch0 pwm high cycles", 32'(h0), 32'd99);
        chk("t3 ch1 pwm high cycles", 32'(h1), 32'd99);

        // 4: one-cycle enable drop mid-period
        setp(0, 600); setp(1, 0);
        periods(12);
        lit("t4 run", 0, 600, 2'b01); lit("t4 ch1", 1, 0, 2'b00);
        repeat (37) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        lit("t4 unchanged", 0, 600, 2'b01);
        align(); lit("t4 idle", 0, 0, 2'b00);
        periods(1); lit("t4 restart", 0, 256, 2'b01);

        // 6: command to zero idles without dead time
        periods(1); lit("t6 up", 0, 512, 2'b01);
        periods(1); lit("t6 full", 0, 600, 2'b01);
        setp(0, 0);
        periods(1); lit("t6 d1", 0, 344, 2'b01);
        periods(1); lit("t6 d2", 0, 88, 2'b01);
        periods(1); lit("t6 idle", 0, 0, 2'b00);
        setp(0, 100);
        periods(1); lit("t6 new", 0, 100, 2'b01);

        // 5: asynchronous reset while pwm is high
        repeat (3) @(negedge clk);
        chk("t5 pwm high before reset", 32'(pwm[0]), 32'd1);
        reset = 1'b1;
        #1;
        chk("t5 reset pwm", 32'(pwm), 32'd0);
        chk("t5 reset direction", 32'(direction), 32'd0);
        chk("t5 reset duty_out", 32'(duty_out), 32'd0);
        chk("t5 reset period_start", 32'(period_start), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (PER) @(negedge clk);
        chk("t5 first period_start", 32'(period_start), 32'd1);

        // random phase: commands change at any cycle, occasional enable drops
        for (int cyc = 0; cyc < 15000; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 249) == 0) setp(c, pick());
            enable = ($urandom_range(0, 1499) == 0) ? 1'b0 : 1'b1;
        end
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/motor_drive_ramp.md
Name: motor_drive_ramp

Overview:
- Multi-channel motor driver: converts per-channel signed power commands into direction codes and fixed-frequency PWM.
- Per-channel duty slew-rate limiting and a mandatory dead-time on direction reversal.
- Sits between the control loop (PID/balance logic) and the H-bridge pins.
- Replaces the fixed 2-channel, shared-duty, 10-bit motor driver.

Parameters:
- CHANNELS, 2: number of independent motor channels.
- PWR_W, 16: width of each signed power command (two's complement).
- DUTY_W, 10: duty resolution; full scale DMAX = 2^DUTY_W-1.
- PERIOD, 4000: clk cycles per PWM period (25 kHz at 100 MHz); >=2.
- RAMP_STEP, 8: maximum duty change per channel per PWM period; >=1.
- DEAD_PERIODS, 4: PWM periods held at duty 0, direction stop, before a reversal.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  drive enable; low forces all channels to idle.
- power  in  CHANNELS*PWR_W  packed signed commands; channel i occupies bits [i*PWR_W +: PWR_W].
- direction  out  2*CHANNELS  per-channel code: 00 stop, 01 forward, 10 backward. Channel i occupies [2i +: 2].
- pwm  out  CHANNELS  per-channel PWM.
- duty_out  out  CHANNELS*DUTY_W  current applied duty, packed as for power.
- period_start  out  1  one-cycle pulse, high in the cycle count==0.

Behaviour:
- Reset (async): period count 0; all duty 0; all states IDLE; direction 00; pwm 0; period_start 0; dead counters 0.
- Period counter: counts 0..PERIOD-1 and wraps. tick = (count==PERIOD-1). All per-channel updates below occur only on tick, so duty never changes mid-period.
- Target: sign S = MSB of power. Magnitude T = |power| saturated to DMAX. The most negative value (e.g. -32768) yields DMAX. power is sampled only on tick.
- Channel states:
  - IDLE: duty 0, direction 00. On tick with enable=1 and T!=0: enter RUN, direction = S (0 gives 01, 1 gives 10), duty = min(RAMP_STEP, T).
  - RUN, same sign as direction or T==0: duty moves toward T by at most RAMP_STEP. No overshoot: if |T-duty| <= RAMP_STEP, duty = T. If the resulting duty is 0 and T==0, enter IDLE (no dead time).
  - RUN, opposite sign and T!=0: duty moves toward 0 by at most RAMP_STEP; direction unchanged. When the resulting duty is 0: enter DEAD, direction 00, dead counter = DEAD_PERIODS.
  - DEAD: duty 0. Decrement the dead counter each tick; on the tick it reaches 0, enter IDLE. Commands during DEAD are ignored. If DEAD_PERIODS==0, go directly to IDLE.
- enable=0: on the next tick every channel goes to IDLE, duty 0, direction 00, dead counter cleared. Ramping is bypassed. Between deassertion and that tick, outputs are unchanged.
- Compare value: cmp = (duty*PERIOD) >> DUTY_W, computed with full-width intermediate (no overflow). Registered on tick together with the new duty.
- pwm register updated every clk with (count < cmp); it lags count by 1 cycle. duty 0 gives constant 0.
- duty_out and direction are registered and change only on tick. period_start is registered from count.
- Channels are fully independent except for the shared counter.

Optional Feature:
- Macro MOTOR_DRIVE_BRAKE_EN.
- Defined: a channel in DEAD drives direction 11 (active brake, both bridge legs low-side). IDLE still drives 00.
- Undefined: DEAD drives 00. No other difference.

Test Plan:
Bench parameters: PERIOD=100, DUTY_W=10, RAMP_STEP=256, DEAD_PERIODS=4, CHANNELS=2.
1. ch0 power=+600, enable=1 -> over successive ticks ch0 duty 256, 512, 600 then holds; direction 01; cmp 58 gives pwm high 58 of 100 cycles per period. ch1 (power 0) stays IDLE.
2. From ch0 steady at 600 forward, power=-300 -> duty 344, 88, 0 (direction 01 until 0). Then 4 periods direction 00 (11 with macro), 1 IDLE period, then direction 10 with duty 256, 300.
3. power=-32768 and power=+5000 on separate channels -> both target 1023. Final duty 1023 after 4 ticks; cmp 99.
4. Running at 600, drop enable for 1 cycle mid-period -> at next tick duty 0, direction 00, IDLE. Re-raising enable ramps from 256.
5. Assert reset mid-period while pwm high -> pwm, direction, duty_out, period_start go to 0 immediately. Counter restarts at 0 after release.
6. Run at 600, then power=0 -> duty 344, 88, 0, then IDLE with no dead periods. A new +100 at the next tick gives duty 100, direction 01.
